hdmi_island_scheduler: RTL

//  Schedules HDMI data-island packet slots in horizontal blanking. Arbitrates up to NUM_REQ

---
 rtl/hdmi_island_scheduler_pkg.sv | 18 +
 rtl/hdmi_island_scheduler_arbiter.sv | 32 +++
 rtl/hdmi_island_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hdmi_island_scheduler_pkg.sv
// Shared definitions for the HDMI data-island scheduler: FSM states, slot
// geometry defaults and the sync-edge helper.
package hdmi_island_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SLOT = 2'd2
  } sched_state_e;

  localparam int SLOT_LEN_DEF = 32;
  localparam int CNT_W        = 5;

  function automatic logic lead_edge(input logic cur, input logic prev, input logic active);
    return (cur == active) && (prev != active);
  endfunction

endpackage

// File: rtl/hdmi_island_scheduler_arbiter.sv
// Combinational round-robin picker: first set bit of the eligible vector
// found by scanning upward from the pointer, with wrap-around.
module hdmi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [IDX_W-1:0] cand;

  // Scan from the far end down so the last hit is the one closest to the pointer.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    cand     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
      if (i_elig[cand]) begin
        o_valid = 1'b1;
        o_idx   = cand;
      end
    end
    if (o_valid) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// Packs packet requests into contiguous fixed-length data-island slots during
// horizontal blanking, with urgent override, round-robin and once-per-frame limits.
module hdmi_island_scheduler
  import hdmi_island_scheduler_pkg::*;
#(
  parameter int               NUM_REQ    = 4,
  parameter int               MAX_SLOTS  = 2,
  parameter int               SLOT_LEN   = SLOT_LEN_DEF,
  parameter logic [NUM_REQ-1:0] FRAME_ONCE = 4'b1100,
  parameter logic             HS_ACTIVE  = 1'b1
) (
  input  logic               i_pixclk,
  input  logic               i_reset_n,
  input  logic               i_hSync,
  input  logic               i_vSync,
  input  logic               i_blank,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_urgent,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_slot_active,
  output logic               o_slot_first,
  output logic [CNT_W-1:0]   o_slot_cnt,
  output logic               o_frame_start,
  output logic               o_overrun
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e       state_q, state_d;
  logic               hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
  logic               vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] used_q, used_d;
  logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [CNT_W-1:0]   slot_idx_q, slot_idx_d;
  logic               slot_first_q, slot_first_d;
  logic               blank_lost_q, blank_lost_d;
  logic               overrun_q, overrun_d;

  logic               line_start, vs_edge, urgent_win;
  logic [NUM_REQ-1:0] elig, urg_elig, arb_vec, arb_onehot, grant_c;
  logic [IDX_W-1:0]   arb_ptr, arb_idx;
  logic               arb_valid;

  // Edges come from the registered sync copies so nothing fires while in reset.
  assign line_start = lead_edge(hs_s1_q, hs_s2_q, HS_ACTIVE);
  assign vs_edge    = lead_edge(vs_s1_q, vs_s2_q, 1'b1);

  assign elig       = i_req & ~(used_q & FRAME_ONCE);
  assign urg_elig   = elig & i_urgent;
  assign urgent_win = |urg_elig;
  // Urgent wins reuse the arbiter as a fixed-priority scan from index 0.
  assign arb_vec    = urgent_win ? urg_elig : elig;
  assign arb_ptr    = urgent_win ? '0 : rr_ptr_q;

  hdmi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_elig   (arb_vec),
    .i_ptr    (arb_ptr),
    .o_onehot (arb_onehot),
    .o_idx    (arb_idx),
    .o_valid  (arb_valid)
  );

  always_comb begin
    hs_s1_d      = i_hSync;
    hs_s2_d      = hs_s1_q;
    vs_s1_d      = i_vSync;
    vs_s2_d      = vs_s1_q;
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    used_d       = vs_edge ? '0 : used_q;
    slot_cnt_d   = slot_cnt_q;
    slot_idx_d   = slot_idx_q;
    slot_first_d = slot_first_q;
    blank_lost_d = blank_lost_q;
    overrun_d    = 1'b0;
    grant_c      = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (line_start && i_blank) begin
          state_d    = ST_ARB;
          slot_idx_d = '0;
        end
      end
      ST_ARB: begin
        if (line_start) overrun_d = 1'b1;
        if (arb_valid) begin
          grant_c         = arb_onehot;
          used_d[arb_idx] = 1'b1;
          if (!urgent_win)
            rr_ptr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + IDX_W'(1);
          state_d      = ST_SLOT;
          slot_cnt_d   = '0;
          slot_first_d = (slot_idx_q == '0);
          blank_lost_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SLOT: begin
        if (line_start) overrun_d = 1'b1;
        if (!i_blank) blank_lost_d = 1'b1;
        if (slot_cnt_q == CNT_W'(SLOT_LEN - 1)) begin
          slot_cnt_d   = '0;
          slot_first_d = 1'b0;
          // A slot is never truncated; a lost blanking interval only ends the island.
          if (blank_lost_q || !i_blank) begin
            state_d   = ST_IDLE;
            overrun_d = 1'b1;
          end else if (int'(slot_idx_q) + 1 < MAX_SLOTS) begin
            state_d    = ST_ARB;
            slot_idx_d = slot_idx_q + CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      hs_s1_q      <= ~HS_ACTIVE;
      hs_s2_q      <= ~HS_ACTIVE;
      vs_s1_q      <= 1'b0;
      vs_s2_q      <= 1'b0;
      rr_ptr_q     <= '0;
      used_q       <= '0;
      slot_cnt_q   <= '0;
      slot_idx_q   <= '0;
      slot_first_q <= 1'b0;
      blank_lost_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_s1_q      <= hs_s1_d;
      hs_s2_q      <= hs_s2_d;
      vs_s1_q      <= vs_s1_d;
      vs_s2_q      <= vs_s2_d;
      rr_ptr_q     <= rr_ptr_d;
      used_q       <= used_d;
      slot_cnt_q   <= slot_cnt_d;
      slot_idx_q   <= slot_idx_d;
      slot_first_q <= slot_first_d;
      blank_lost_q <= blank_lost_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_grant       = grant_c;
  assign o_slot_active = (state_q == ST_SLOT);
  assign o_slot_first  = slot_first_q;
  assign o_slot_cnt    = slot_cnt_q;
  assign o_frame_start = vs_edge;
  assign o_overrun     = overrun_q;

endmodule
